// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
// Fetch side drives the request; memory side answers.
interface fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches
// one word per strobe into the IF/ID register.
module fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                TIMEOUT   = 255,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stage_reset_n,
  input  logic              if_id_wren,
  input  logic              pc_wren,
  input  logic [ADDR_W-1:0] pc_next_in,
  fetch_stage_if.master     imem,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        cnt;
  logic              drop;

  assign pc_out     = pc;
  assign fetch_busy = (state != S_IDLE);

  // PC follows pc_wren in every state, independent of fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (pc_wren) begin
      pc <= pc_next_in;
    end
  end

  // Fetch FSM: request, wait for data or timeout, capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      if_id_pc       <= '0;
      if_id_instr    <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      fetch_err      <= 1'b0;
      cnt            <= '0;
      drop           <= 1'b0;
    end else if (!stage_reset_n) begin
      state         <= S_IDLE;
      imem.imem_req <= 1'b0;
      if_id_valid   <= 1'b0;
      if_id_instr   <= NOP_INSTR;
      if (state == S_WAIT) begin
        drop <= 1'b1;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (drop) begin
            if (imem.imem_rvalid) begin
              drop <= 1'b0;
            end
          end else if (if_id_wren) begin
            if (pc[1:0] == 2'b00) begin
              if_id_valid    <= 1'b0;
              imem.imem_addr <= pc;
              imem.imem_req  <= 1'b1;
              state          <= S_REQ;
            end else begin
              fetch_err   <= 1'b1;
              if_id_instr <= NOP_INSTR;
              if_id_pc    <= pc;
              if_id_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (imem.imem_ready) begin
            imem.imem_req <= 1'b0;
            cnt           <= '0;
            if (imem.imem_rvalid) begin
              if_id_instr <= imem.imem_rdata;
              if_id_pc    <= imem.imem_addr;
              if_id_valid <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if_id_instr <= imem.imem_rdata;
            if_id_pc    <= imem.imem_addr;
            if_id_valid <= 1'b1;
            state       <= S_IDLE;
          end else if (cnt >= TO_LAST) begin
            fetch_err   <= 1'b1;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= imem.imem_addr;
            if_id_valid <= 1'b1;
            drop        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
